// File: rtl/shift_sequencer.sv
// Multi-step shift controller. It loads an operand and then applies a one-position
// 4-bit shifter once per clock, `amount` times, pulsing done when the count is spent.

module barrel_shifter (
  input  logic [2:0] cod,
  input  logic [3:0] E,
  output logic [3:0] S
);
  always_comb begin
    S = E;
    case (cod)
      3'b001:  S = {1'b0, E[3:1]};
      3'b010:  S = {E[2:0], 1'b0};
      3'b011:  S = {E[0], E[3:1]};
      3'b101:  S = {E[3], E[3:1]};
      3'b110:  S = {E[3], E[1:0], 1'b0};
      3'b111:  S = {E[2:0], E[3]};
      default: S = E;
    endcase
  end
endmodule

module shift_sequencer #(
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [3:0]       data_in,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nstate;
  logic [3:0]       acc, shf;
  logic [AMT_W-1:0] cnt;
  logic [2:0]       op_r;
  logic             accept;

  barrel_shifter u_shf (.cod(op_r), .E(acc), .S(shf));

  // DONE accepts like IDLE so back-to-back requests see no bubble
  assign accept = start && (state == IDLE || state == DONE);

  always_comb begin
    nstate = state;
    case (state)
      IDLE, DONE: begin
        if (start)
          nstate = (amount == '0 || op[1:0] == 2'b00) ? DONE : RUN;
        else
          nstate = IDLE;
      end
      RUN:     if (cnt == AMT_W'(1)) nstate = DONE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      cnt  <= '0;
      op_r <= '0;
    end else if (accept) begin
      acc  <= data_in;
      op_r <= op;
      cnt  <= amount;
    end else if (state == RUN) begin
      acc <= shf;
      cnt <= cnt - AMT_W'(1);
    end
  end

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign result = acc;
endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: each accepted request pushes its expected
// result, busy length and done latency; the done pulse pops and compares them.

module tb_shift_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] data_in = '0;
  logic [2:0] amount = '0;
  logic       busy, done;
  logic [3:0] result;

  shift_sequencer #(.AMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .data_in(data_in),
    .amount(amount), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] res;
    int         nbusy;
    int         lat;
    int         t0;
  } exp_t;

  exp_t       sb[$];
  int         nvec = 0, nmis = 0;
  int         cyc = 0, busy_cnt = 0, done_seen = 0;
  logic [3:0] last_res = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: one step written arithmetically rather than by bit wiring
  function automatic logic [3:0] step(input logic [2:0] o, input logic [3:0] e);
    logic [7:0] dbl;
    logic signed [3:0] s;
    dbl = {e, e};
    s   = e;
    case (o)
      3'b001:  return e / 2;
      3'b010:  return 4'((e * 2) % 16);
      3'b011:  begin dbl = dbl >> 1; return dbl[3:0]; end
      3'b101:  return 4'(s >>> 1);
      3'b110:  return (e & 4'b1000) | 4'((e * 2) & 4'b0110);
      3'b111:  begin dbl = dbl << 1; return dbl[7:4]; end
      default: return e;
    endcase
  endfunction

  function automatic logic [3:0] model(input logic [2:0] o, input logic [3:0] d, input int n);
    logic [3:0] v = d;
    for (int i = 0; i < n; i++) v = step(o, v);
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) busy_cnt = 0;
    else begin
      if (busy && done) chk("busy_done_overlap", 1, 0);
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("busy_cycles", busy_cnt, e.nbusy);
          chk("done_latency", cyc - e.t0, e.lat);
          last_res = e.res;
        end
        busy_cnt = 0;
        done_seen++;
      end
    end
  end

  // Called #1 after a negedge; the request is accepted on the following posedge.
  task automatic issue(input logic [2:0] o, input logic [3:0] d, input logic [2:0] n,
                       input logic [3:0] exp_res, input bit push);
    exp_t e;
    start = 1'b1; op = o; data_in = d; amount = n;
    e.res   = exp_res;
    e.nbusy = (n == 0 || o[1:0] == 2'b00) ? 0 : int'(n);
    e.lat   = e.nbusy + 1;
    e.t0    = cyc;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done_seen != prev) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [2:0] o, input logic [3:0] d, input logic [2:0] n,
                     input logic [3:0] exp_res);
    int ds = done_seen;
    issue(o, d, n, exp_res, 1'b1);
    wait_done(ds);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      chk("idle_hold", {busy, done, result}, {2'b00, last_res});
    end
  endtask

  initial begin
    int ds;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;

    run(3'b001, 4'b1011, 3'd2, 4'b0010);
    idle(2);

    // rotate left by 5; a start pulse with other operands mid-RUN must be ignored
    ds = done_seen;
    issue(3'b111, 4'b1001, 3'd5, 4'b0011, 1'b1);
    @(negedge clk); #1;
    start = 1'b1; op = 3'b000; data_in = 4'hF; amount = 3'd0;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b010; data_in = 4'h5;
    wait_done(ds);
    idle(3);

    run(3'b101, 4'b1000, 3'd3, 4'b1111);
    run(3'b110, 4'b1011, 3'd2, 4'b1100);
    idle(1);
    run(3'b011, 4'b0110, 3'd0, 4'b0110);
    run(3'b100, 4'b0110, 3'd7, 4'b0110);
    run(3'b011, 4'b1101, 3'd4, 4'b1101);
    run(3'b001, 4'b1111, 3'd7, 4'b0000);
    run(3'b101, 4'b1010, 3'd7, 4'b1111);
    idle(1);

    // back-to-back: second request accepted in the first request's DONE cycle
    run(3'b001, 4'b1000, 3'd1, 4'b0100);
    run(3'b010, 4'b0011, 3'd1, 4'b0110);
    idle(2);

    // asynchronous reset inside the 3rd RUN cycle discards the operation
    issue(3'b001, 4'b1111, 3'd7, 4'b0000, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_result", result, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    last_res = '0;
    idle(2);
    run(3'b010, 4'b0101, 3'd3, 4'b1000);

    for (int i = 0; i < 12; i++) begin
      logic [2:0] o, n;
      logic [3:0] d;
      o = 3'($urandom_range(0, 7));
      d = 4'($urandom_range(0, 15));
      n = 3'($urandom_range(0, 7));
      run(o, d, n, model(o, d, int'(n)));
      if (i % 3 == 0) idle(1);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
